// File: rtl/dac_cfg_serializer.sv
// Serial configuration transmitter for dac_driver: shifts a 256-bit payload out on gpio_ctrl as data + per-target strobe.
// Optional DAC_CFG_CMD_FIFO_EN adds a 2-entry command FIFO in front of the engine.
module dac_cfg_serializer #(
    parameter int unsigned SDATA_BIT           = 0,
    parameter int unsigned CYCLE_COUNT_CLK_BIT = 1,
    parameter int unsigned MASK_CLK_BIT        = 2,
    parameter int unsigned MUX_SET_CLK_BIT     = 3,
    parameter int unsigned SETUP_CYC           = 2,
    parameter int unsigned HIGH_CYC            = 2,
    parameter int unsigned LOW_CYC             = 2,
    parameter int unsigned MUX_PULSES          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_target,
    input  logic [255:0] cmd_data,
    output logic [15:0]  gpio_ctrl,
    output logic         select_out,
    output logic         busy,
    output logic         done,
    output logic         cmd_err
);

    localparam int unsigned DATA_W  = 256;
    localparam int unsigned GPIO_W  = 16;
    localparam int unsigned PHASE_W = 8;
    localparam int unsigned BIT_W   = 9;

    localparam logic [1:0] TGT_MUX  = 2'd0;
    localparam logic [1:0] TGT_CYC  = 2'd1;
    localparam logic [1:0] TGT_MASK = 2'd2;
    localparam logic [1:0] TGT_BAD  = 2'd3;

    localparam logic [GPIO_W-1:0] SDATA_M = GPIO_W'(1) << SDATA_BIT;
    localparam logic [GPIO_W-1:0] CYC_M   = GPIO_W'(1) << CYCLE_COUNT_CLK_BIT;
    localparam logic [GPIO_W-1:0] MASK_M  = GPIO_W'(1) << MASK_CLK_BIT;
    localparam logic [GPIO_W-1:0] MUX_M   = GPIO_W'(1) << MUX_SET_CLK_BIT;

    localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] HIGH_LAST  = PHASE_W'(HIGH_CYC - 1);
    localparam logic [PHASE_W-1:0] LOW_LAST   = PHASE_W'(LOW_CYC - 1);
    localparam logic [BIT_W-1:0]   MUX_LAST   = BIT_W'(MUX_PULSES - 1);
    localparam logic [BIT_W-1:0]   WORD_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    typedef struct packed {
        logic [1:0]        target;
        logic [DATA_W-1:0] data;
    } cmd_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [GPIO_W-1:0]   gpio_q, gpio_d;
    logic                select_q, select_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    cmd_t                eng_cmd;
    logic                eng_valid;
    logic                eng_take;
    logic [BIT_W-1:0]    last_bit;
    logic [GPIO_W-1:0]   strobe_m;

    assign eng_take = eng_valid & (state_q == IDLE);

`ifdef DAC_CFG_CMD_FIFO_EN
    // Two-entry command FIFO; the engine pops whenever it is idle.
    cmd_t       mem_q [2];
    cmd_t       mem_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       push;

    assign cmd_ready = (cnt_q != 2'd2);
    assign push      = cmd_valid & cmd_ready;
    assign eng_valid = (cnt_q != 2'd0);
    assign eng_cmd   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{target: cmd_target, data: cmd_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (eng_take) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(eng_take);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`else
    assign cmd_ready = (state_q == IDLE);
    assign eng_valid = cmd_valid;
    assign eng_cmd   = '{target: cmd_target, data: cmd_data};
`endif

    assign last_bit = (tgt_q == TGT_MUX) ? MUX_LAST : WORD_LAST;

    // Phase/bit sequencing; registered outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (eng_take) begin
                    if (eng_cmd.target == TGT_BAD) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = SETUP;
                        phase_d = '0;
                        bit_d   = '0;
                        shift_d = eng_cmd.data;
                        tgt_d   = eng_cmd.target;
                    end
                end
            end
            SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = HIGH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            LOW: begin
                if (phase_q != LOW_LAST) begin
                    phase_d = phase_q + PHASE_W'(1);
                end else if (bit_q == last_bit) begin
                    state_d = IDLE;
                    phase_d = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = SETUP;
                    phase_d = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    // Mux select repeats cmd_data[0] on every pulse.
                    if (tgt_q != TGT_MUX) begin
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (tgt_d)
            TGT_MUX:  strobe_m = MUX_M;
            TGT_CYC:  strobe_m = CYC_M;
            TGT_MASK: strobe_m = MASK_M;
            default:  strobe_m = '0;
        endcase

        gpio_d   = '0;
        select_d = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
        if (state_d != IDLE) begin
            gpio_d = (shift_d[0] ? SDATA_M : '0) | ((state_d == HIGH) ? strobe_m : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tgt_q    <= TGT_MUX;
            gpio_q   <= '0;
            select_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tgt_q    <= tgt_d;
            gpio_q   <= gpio_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign gpio_ctrl  = gpio_q;
    assign select_out = select_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_err    = err_q;

endmodule
